// File: rtl/seg7_pkg.sv
// Shared constants, hex segment table and display buffer type for the
// eight-digit seven-segment scanner.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned CNT_W      = 16;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

  // Active-low {CA..CG} patterns for hex digits 0..F.
  localparam logic [SEG_W-1:0] HEX_LUT [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  typedef struct packed {
    logic [NUM_DIGITS*NIB_W-1:0] digits;
    logic [NUM_DIGITS-1:0]       en;
    logic [NUM_DIGITS-1:0]       dp;
  } disp_buf_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment pattern lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  assign seg_c = HEX_LUT[nibble];

endmodule

// File: rtl/seg7_scanner.sv
// Time-multiplexed eight-digit seven-segment scanner with frame-synchronous
// double buffering. Define SEG7_SCANNER_BLANK_EN to blank the start of each slot.
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned PRESCALE     = 12500,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] i_digits,
  input  logic [7:0]  i_en,
  input  logic [7:0]  i_dp,
  input  logic        i_load,
  output logic [7:0]  AN,
  output logic [6:0]  Digits_Bits,
  output logic        DP,
  output logic        o_frame_start
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  disp_buf_t             pend_q, pend_d;
  disp_buf_t             act_q, act_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  fs_q, fs_d;

  logic                  wrap_c;
  logic                  boundary_c;
  logic                  blank_c;
  logic                  lit_c;
  disp_buf_t             load_buf_c;
  logic [NIB_W-1:0]      nib_c;
  logic [SEG_W-1:0]      hex_c;

`ifdef SEG7_SCANNER_BLANK_EN
  assign blank_c = (cnt_q < CNT_W'(BLANK_CYCLES));
`else
  logic blank_cfg_unused_c;
  assign blank_cfg_unused_c = (BLANK_CYCLES != 0);
  assign blank_c            = 1'b0;
`endif

  // Slot timing: cnt walks the slot, idx advances on each slot wrap.
  always_comb begin
    wrap_c     = (cnt_q == CNT_LAST);
    boundary_c = wrap_c && (idx_q == IDX_LAST);
    cnt_d      = wrap_c ? '0 : cnt_q + CNT_W'(1);
    idx_d      = wrap_c ? idx_q + IDX_W'(1) : idx_q;
  end

  // Double buffer: loads land in pending, promoted only at a frame boundary.
  // A load on the boundary itself bypasses pending straight into active.
  always_comb begin
    load_buf_c.digits = i_digits;
    load_buf_c.en     = i_en;
    load_buf_c.dp     = i_dp;
    pend_d            = pend_q;
    pend_valid_d      = pend_valid_q;
    act_d             = act_q;
    if (i_load) begin
      pend_d       = load_buf_c;
      pend_valid_d = 1'b1;
    end
    if (boundary_c) begin
      pend_valid_d = 1'b0;
      if (i_load) begin
        act_d = load_buf_c;
      end else if (pend_valid_q) begin
        act_d = pend_q;
      end
    end
  end

  assign nib_c = act_q.digits[{idx_q, 2'b00} +: NIB_W];

  seg7_hex_decode u_hex_decode (
    .nibble (nib_c),
    .seg_c  (hex_c)
  );

  // Drive outputs for the current slot; they appear one cycle later.
  always_comb begin
    lit_c = act_q.en[idx_q] && !blank_c;
    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    fs_d  = boundary_c;
    if (lit_c) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = hex_c;
      dp_d  = ~act_q.dp[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_q       <= '0;
      act_q        <= '0;
      pend_valid_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      fs_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      act_q        <= act_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      fs_q         <= fs_d;
    end
  end

  assign AN            = an_q;
  assign Digits_Bits   = seg_q;
  assign DP            = dp_q;
  assign o_frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// Scoreboard bench for seg7_scanner: stimulus queues expected frames, a
// monitor aligned to o_frame_start checks every slot cycle of those frames.
module tb_seg7_scanner;

  localparam int unsigned PRESCALE     = 4;
  localparam int unsigned BLANK_CYCLES = 1;
`ifdef SEG7_SCANNER_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  localparam logic [63:0] AN_ALL  = {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
  localparam logic [63:0] AN_NONE = {8{8'hFF}};
  localparam logic [55:0] SEG_NONE = {8{7'h7F}};

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] i_digits = '0;
  logic [7:0]  i_en = '0;
  logic [7:0]  i_dp = '0;
  logic        i_load = 1'b0;
  logic [7:0]  AN;
  logic [6:0]  Digits_Bits;
  logic        DP;
  logic        o_frame_start;

  always #5 clk = ~clk;

  seg7_scanner #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_digits      (i_digits),
    .i_en          (i_en),
    .i_dp          (i_dp),
    .i_load        (i_load),
    .AN            (AN),
    .Digits_Bits   (Digits_Bits),
    .DP            (DP),
    .o_frame_start (o_frame_start)
  );

  typedef struct packed {
    int          frame;
    logic [63:0] an;
    logic [55:0] seg;
    logic [7:0]  dp;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mon_p = -1;
  int   frame_cnt = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endfunction

  function automatic void push(input int frame, input logic [63:0] an, input logic [55:0] seg, input logic [7:0] dp);
    exp_t e;
    e.frame = frame;
    e.an    = an;
    e.seg   = seg;
    e.dp    = dp;
    exp_q.push_back(e);
  endfunction

  // Monitor: p = cycles since the last o_frame_start; output at p reflects slot (p-1)/4.
  always @(negedge clk) begin
    int   s;
    int   ph;
    exp_t e;
    if (!rstn) begin
      mon_p = -1;
    end else begin
      if (mon_p >= 0)
        check("frame_start", 32'(o_frame_start), 32'(mon_p == 31));
      if (o_frame_start) begin
        mon_p = 0;
        frame_cnt++;
        while (exp_q.size() > 0 && exp_q[0].frame < frame_cnt) begin
          n_cmp++;
          n_bad++;
          $display("FAIL missed_frame: got frame %0d want frame %0d", frame_cnt, exp_q[0].frame);
          void'(exp_q.pop_front());
        end
      end else if (mon_p >= 0) begin
        mon_p++;
      end
      if (mon_p >= 1 && mon_p <= 31 && exp_q.size() > 0 && exp_q[0].frame == frame_cnt) begin
        e  = exp_q[0];
        s  = (mon_p - 1) / 4;
        ph = (mon_p - 1) % 4;
        if (BLANK_ON && ph == 0) begin
          check($sformatf("AN f%0d s%0d ph%0d", frame_cnt, s, ph), 32'(AN), 32'h0FF);
          check($sformatf("SEG f%0d s%0d ph%0d", frame_cnt, s, ph), 32'(Digits_Bits), 32'h07F);
          check($sformatf("DP f%0d s%0d ph%0d", frame_cnt, s, ph), 32'(DP), 32'h1);
        end else begin
          check($sformatf("AN f%0d s%0d ph%0d", frame_cnt, s, ph), 32'(AN), 32'(e.an[s*8 +: 8]));
          check($sformatf("SEG f%0d s%0d ph%0d", frame_cnt, s, ph), 32'(Digits_Bits), 32'(e.seg[s*7 +: 7]));
          check($sformatf("DP f%0d s%0d ph%0d", frame_cnt, s, ph), 32'(DP), 32'(e.dp[s]));
        end
        if (mon_p == 31) void'(exp_q.pop_front());
      end
    end
  end

  // Return #1 into the cycle whose frame position is pt (1..31).
  task automatic sync_to(input int pt);
    int g = 0;
    int tgt = (pt + 31) % 32;
    @(posedge clk);
    while (mon_p != tgt && g < 200) begin
      @(posedge clk);
      g++;
    end
    if (g >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sync_timeout: got pos %0d want %0d", mon_p, tgt);
    end
    #1;
  endtask

  task automatic load(input logic [31:0] d, input logic [7:0] en, input logic [7:0] dp);
    i_digits = d;
    i_en     = en;
    i_dp     = dp;
    i_load   = 1'b1;
    @(posedge clk);
    #1 i_load = 1'b0;
  endtask

  task automatic wait_empty();
    int g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(posedge clk);
      g++;
    end
    if (g >= 500) begin
      n_cmp++;
      n_bad++;
      $display("FAIL queue_drain: got %0d pending frames want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_AN"}, 32'(AN), 32'h0FF);
    check({tag, "_SEG"}, 32'(Digits_Bits), 32'h07F);
    check({tag, "_DP"}, 32'(DP), 32'h1);
    check({tag, "_FS"}, 32'(o_frame_start), 32'h0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rstn = 1'b1;

    // Nothing loaded: two whole frames stay dark.
    push(1, AN_NONE, SEG_NONE, 8'hFF);
    push(2, AN_NONE, SEG_NONE, 8'hFF);
    wait_empty();

    // Mid-frame load of 0..7, DP on digit 0 only; shown from the next frame on.
    sync_to(10);
    n = frame_cnt;
    load(32'h76543210, 8'hFF, 8'h01);
    push(n + 1, AN_ALL, {7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01}, 8'hFE);
    push(n + 2, AN_ALL, {7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01}, 8'hFE);
    wait_empty();

    // Load exactly on the frame boundary cycle: visible in the very next frame.
    sync_to(31);
    n = frame_cnt;
    load(32'h89ABCDEF, 8'hFF, 8'h80);
    push(n + 1, AN_ALL, {7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38}, 8'h7F);
    push(n + 2, AN_ALL, {7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38}, 8'h7F);
    wait_empty();

    // Partial enable mask: disabled digits stay dark.
    sync_to(12);
    n = frame_cnt;
    load(32'h13579BDF, 8'h5A, 8'hFF);
    push(n + 1, {8'hFF, 8'hBF, 8'hFF, 8'hEF, 8'hF7, 8'hFF, 8'hFD, 8'hFF},
         {7'h7F, 7'h06, 7'h7F, 7'h0F, 7'h04, 7'h7F, 7'h42, 7'h7F}, 8'hA5);
    wait_empty();

    // Two loads in one frame: only the last one is ever displayed.
    sync_to(5);
    n = frame_cnt;
    load(32'h00000000, 8'hFF, 8'h00);
    sync_to(20);
    load(32'hFFFFFFFF, 8'hFF, 8'h00);
    push(n + 1, AN_ALL, {8{7'h38}}, 8'hFF);
    push(n + 2, AN_ALL, {8{7'h38}}, 8'hFF);
    wait_empty();

    // Reset while digit 5 is lit with a load pending.
    sync_to(18);
    load(32'h22222222, 8'hFF, 8'hFF);
    sync_to(23);
    check("pre_reset_AN", 32'(AN), 32'h0DF);
    rstn = 1'b0;
    #1 check_reset_outputs("async_reset");
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("held_reset");
    rstn = 1'b1;
    n = frame_cnt;
    push(n + 1, AN_NONE, SEG_NONE, 8'hFF);
    push(n + 2, AN_NONE, SEG_NONE, 8'hFF);
    wait_empty();

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion want finish before 100000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
